memwb_pipe: RTL and testbench

MEMWB_PIPE -- requirements
Module: memwb_pipe

---
 rtl/memwb_pkg.sv | 26 ++
 rtl/memwb_skid.sv | 100 ++++++++++
 rtl/memwb_pipe.sv | 67 ++++++
 tb/tb_memwb_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/memwb_pkg.sv
// Shared types for the MEM/WB pipeline register: payload layout and skid controller states.
// Optional HI/LO payload fields exist only when MEMWB_HILO_EN is defined.
package memwb_pkg;

  localparam int unsigned MEMWB_DATA_W = 32;
  localparam int unsigned MEMWB_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

  typedef struct packed {
    logic [MEMWB_DATA_W-1:0]   dreg;
    logic [MEMWB_ADDR_W-1:0]   wa;
    logic                      wreg;
    logic                      mreg;
    logic [MEMWB_DATA_W/8-1:0] dre;
`ifdef MEMWB_HILO_EN
    logic                      whilo;
    logic [2*MEMWB_DATA_W-1:0] hilo;
`endif
  } memwb_payload_t;

endpackage

// File: rtl/memwb_skid.sv
// Generic two-entry skid buffer over an opaque payload vector; ready and valid are registered
// so there is no combinational path from out_ready_i to in_ready_o.
module memwb_skid
  import memwb_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q;
  logic         valid_q;
  logic         in_fire_s;
  logic         out_fire_s;

  assign in_fire_s   = in_valid_i && ready_q;
  assign out_fire_s  = valid_q && out_ready_i;
  assign in_ready_o  = ready_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = main_q;

  // Next-state and datapath selection; main is zeroed whenever it becomes empty so bubbles read 0.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire_s) begin
            state_d = ST_HALF;
            main_d  = in_data_i;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_HALF: begin
          if (in_fire_s && out_fire_s) begin
            main_d = in_data_i;
          end else if (in_fire_s) begin
            state_d = ST_FULL;
            skid_d  = in_data_i;
          end else if (out_fire_s) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end else begin
            state_d = ST_HALF;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            state_d = ST_HALF;
            main_d  = skid_q;
            skid_d  = '0;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // State and payload registers with ready/valid derived from the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= (state_d != ST_FULL);
      valid_q <= (state_d != ST_EMPTY);
    end
  end

endmodule

// File: rtl/memwb_pipe.sv
// MEM/WB pipeline register with a two-entry skid buffer, flush and synchronous reset.
// Define MEMWB_HILO_EN to add the HI/LO write request and data to the carried payload.
module memwb_pipe
  import memwb_pkg::*;
#(
  parameter int unsigned DATA_W = MEMWB_DATA_W,
  parameter int unsigned ADDR_W = MEMWB_ADDR_W,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] mem_dreg,
  input  logic [ADDR_W-1:0] mem_wa,
  input  logic              mem_wreg,
  input  logic              mem_mreg,
  input  logic [BE_W-1:0]   mem_dre,
`ifdef MEMWB_HILO_EN
  input  logic                mem_whilo,
  input  logic [2*DATA_W-1:0] mem_hilo,
  output logic                wb_whilo,
  output logic [2*DATA_W-1:0] wb_hilo,
`endif
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_dreg,
  output logic [ADDR_W-1:0] wb_wa,
  output logic              wb_wreg,
  output logic              wb_mreg,
  output logic [BE_W-1:0]   wb_dre
);

`ifdef MEMWB_HILO_EN
  localparam int unsigned HILO_W = 1 + 2 * DATA_W;
`else
  localparam int unsigned HILO_W = 0;
`endif
  localparam int unsigned PAY_W = DATA_W + ADDR_W + 2 + BE_W + HILO_W;

  logic [PAY_W-1:0] pay_in_s;
  logic [PAY_W-1:0] pay_out_s;

`ifdef MEMWB_HILO_EN
  assign pay_in_s = {mem_whilo, mem_hilo, mem_dreg, mem_wa, mem_wreg, mem_mreg, mem_dre};
  assign {wb_whilo, wb_hilo, wb_dreg, wb_wa, wb_wreg, wb_mreg, wb_dre} = pay_out_s;
`else
  assign pay_in_s = {mem_dreg, mem_wa, mem_wreg, mem_mreg, mem_dre};
  assign {wb_dreg, wb_wa, wb_wreg, wb_mreg, wb_dre} = pay_out_s;
`endif

  memwb_skid #(
    .W (PAY_W)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (mem_valid),
    .in_ready_o  (mem_ready),
    .in_data_i   (pay_in_s),
    .out_valid_o (wb_valid),
    .out_ready_i (wb_ready),
    .out_data_o  (pay_out_s)
  );

endmodule

// File: tb/tb_memwb_pipe.sv
// Scoreboard bench for memwb_pipe: a 2-deep queue model predicts held beats, ready and valid.
module tb_memwb_pipe;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, mem_valid, mem_ready, mem_wreg, mem_mreg;
  logic [DW-1:0] mem_dreg;
  logic [AW-1:0] mem_wa;
  logic [BW-1:0] mem_dre;
  logic          wb_valid, wb_ready, wb_wreg, wb_mreg;
  logic [DW-1:0] wb_dreg;
  logic [AW-1:0] wb_wa;
  logic [BW-1:0] wb_dre;
`ifdef MEMWB_HILO_EN
  logic            mem_whilo, wb_whilo;
  logic [2*DW-1:0] mem_hilo, wb_hilo;
`endif

  always #5 clk = ~clk;

  memwb_pipe #(.DATA_W(DW), .ADDR_W(AW), .BE_W(BW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_dreg  (mem_dreg),
    .mem_wa    (mem_wa),
    .mem_wreg  (mem_wreg),
    .mem_mreg  (mem_mreg),
    .mem_dre   (mem_dre),
`ifdef MEMWB_HILO_EN
    .mem_whilo (mem_whilo),
    .mem_hilo  (mem_hilo),
    .wb_whilo  (wb_whilo),
    .wb_hilo   (wb_hilo),
`endif
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_dreg   (wb_dreg),
    .wb_wa     (wb_wa),
    .wb_wreg   (wb_wreg),
    .wb_mreg   (wb_mreg),
    .wb_dre    (wb_dre)
  );

  typedef struct packed {
    logic [DW-1:0]   dreg;
    logic [AW-1:0]   wa;
    logic            wreg;
    logic            mreg;
    logic [BW-1:0]   dre;
    logic            whilo;
    logic [2*DW-1:0] hilo;
  } beat_t;

  beat_t sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic beat_t rnd_beat();
    beat_t b;
    b.dreg  = $urandom;
    b.wa    = AW'($urandom);
    b.wreg  = 1'($urandom);
    b.mreg  = 1'($urandom);
    b.dre   = BW'($urandom);
    b.whilo = 1'($urandom);
    b.hilo  = {$urandom, $urandom};
`ifndef MEMWB_HILO_EN
    b.whilo = 1'b0;
    b.hilo  = '0;
`endif
    return b;
  endfunction

  function automatic beat_t mk(input int d);
    beat_t b;
    b       = rnd_beat();
    b.dreg  = DW'(d);
    b.wa    = AW'(d);
    b.wreg  = 1'b1;
    return b;
  endfunction

  function automatic beat_t dut_beat();
    beat_t b;
    b.dreg = wb_dreg;
    b.wa   = wb_wa;
    b.wreg = wb_wreg;
    b.mreg = wb_mreg;
    b.dre  = wb_dre;
`ifdef MEMWB_HILO_EN
    b.whilo = wb_whilo;
    b.hilo  = wb_hilo;
`else
    b.whilo = 1'b0;
    b.hilo  = '0;
`endif
    return b;
  endfunction

  // One clock of stimulus; the model accepts a beat when fewer than two are held.
  task automatic offer(input bit v, input beat_t b, input bit rdy, input bit fl, input bit rs,
                       output bit acc);
    mem_valid = v;
    mem_dreg  = b.dreg;
    mem_wa    = b.wa;
    mem_wreg  = b.wreg;
    mem_mreg  = b.mreg;
    mem_dre   = b.dre;
`ifdef MEMWB_HILO_EN
    mem_whilo = b.whilo;
    mem_hilo  = b.hilo;
`endif
    wb_ready  = rdy;
    flush     = fl;
    rst       = rs;
    acc       = v && (sb.size() < 2) && !fl && !rs;
    @(posedge clk);
    if (rs || fl) sb.delete();
    else if (acc) sb.push_back(b);
    #1;
  endtask

  // Monitor: compare DUT outputs against the model head, then retire on a modelled output transfer.
  always @(negedge clk) begin
    if (mon_en) begin
      int occ;
      occ = sb.size();
      chk("wb_valid", wb_valid, occ > 0);
      chk("mem_ready", mem_ready, occ < 2);
      if (occ > 0) chk("payload", dut_beat(), sb[0]);
      else begin
        chk("bubble_wreg", wb_wreg, 1'b0);
`ifdef MEMWB_HILO_EN
        chk("bubble_whilo", wb_whilo, 1'b0);
`endif
      end
      if (occ > 0 && wb_ready && !flush && !rst) void'(sb.pop_front());
    end
  end

  initial begin
    bit    acc;
    beat_t cur;
    beat_t idle;
    idle = '0;

    offer(1'b1, mk(3), 1'b1, 1'b0, 1'b1, acc);
    offer(1'b0, idle, 1'b1, 1'b0, 1'b1, acc);
    offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
    mon_en = 1'b1;
    chk("reset_valid", wb_valid, 1'b0);
    chk("reset_ready", mem_ready, 1'b1);
    chk("reset_dreg", wb_dreg, '0);

    // Streaming 1..8 at full rate.
    for (int i = 1; i <= 8; i++) begin
      offer(1'b1, mk(i), 1'b1, 1'b0, 1'b0, acc);
      chk("stream_accept", acc, 1'b1);
      chk("stream_latency", wb_dreg, i);
    end
    offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
    offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

    // Stall: 5 and 6 held, 7 held off until space frees.
    offer(1'b1, mk(5), 1'b0, 1'b0, 1'b0, acc);
    offer(1'b1, mk(6), 1'b0, 1'b0, 1'b0, acc);
    chk("stall_ready", mem_ready, 1'b0);
    offer(1'b1, mk(7), 1'b0, 1'b0, 1'b0, acc);
    chk("stall_hold_dreg", wb_dreg, 5);
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) offer(1'b1, mk(7), 1'b1, 1'b0, 1'b0, acc);
    chk("stall_resume", acc, 1'b1);
    for (int t = 0; t < 3; t++) offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

    // Flush while FULL with a wa=9 beat offered.
    offer(1'b1, mk(10), 1'b0, 1'b0, 1'b0, acc);
    offer(1'b1, mk(11), 1'b0, 1'b0, 1'b0, acc);
    offer(1'b1, mk(9), 1'b1, 1'b1, 1'b0, acc);
    chk("flush_valid", wb_valid, 1'b0);
    chk("flush_ready", mem_ready, 1'b1);
    offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

    // Bubble with wreg asserted on the input.
    for (int t = 0; t < 3; t++) begin
      offer(1'b0, mk(12), 1'b1, 1'b0, 1'b0, acc);
      chk("bubble_in_wreg", wb_wreg, 1'b0);
    end

    // Reset while FULL.
    offer(1'b1, mk(20), 1'b0, 1'b0, 1'b0, acc);
    offer(1'b1, mk(21), 1'b0, 1'b0, 1'b0, acc);
    offer(1'b1, mk(22), 1'b1, 1'b1, 1'b1, acc);
    chk("rst_full_valid", wb_valid, 1'b0);
    chk("rst_full_dreg", wb_dreg, '0);
    chk("rst_full_wa", wb_wa, '0);
`ifdef MEMWB_HILO_EN
    chk("rst_full_hilo", wb_hilo, '0);
`endif
    offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);

    // Randomized traffic; an offered beat is held until accepted.
    cur = rnd_beat();
    for (int c = 0; c < 800; c++) begin
      offer(($urandom % 4) != 0, cur, ($urandom % 3) != 0, ($urandom % 40) == 0,
            ($urandom % 150) == 0, acc);
      if (acc) cur = rnd_beat();
    end
    for (int t = 0; t < 4; t++) offer(1'b0, idle, 1'b1, 1'b0, 1'b0, acc);
    chk("drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
